// File: rtl/node_gate_ctrl.sv
// -----------------------------------------------------------------------------
// node_gate_ctrl
//   Sequencer for CHANNELS gated core domains. Each channel walks
//   OFF -> HOLD -> RUN -> DRAIN -> OFF: the gated clock is enabled first, the
//   domain reset is held low for RES_HOLD cycles, the core then owns its AXI
//   bridge until it finishes (fin) or is released (activate low), and the
//   channel is only switched off once its outstanding bus traffic has drained.
//   At most MAX_ACTIVE channels are out of OFF at once; new requesters are
//   admitted one per cycle in round-robin order.
//
// Parameters
//   CHANNELS    number of gated domains (1..16)
//   MAX_ACTIVE  cap on channels not in OFF (1..CHANNELS)
//   RES_HOLD    cycles of HOLD (gated reset low, clock running) (1..255)
//
// Ports
//   clk          single clock for every flop in the block
//   res_n        asynchronous active-low reset
//   activate     per-channel run request (level)
//   fin          per-channel completion pulse, honoured only in RUN
//   bus_busy     per-channel core-side AXI transaction outstanding
//   clk_en       enable to the external glitch-free clock-gating cell
//   res_n_gated  active-low reset into the gated domain
//   sel          AXI mux select, 1 = core owns the bridge
//   done         one-cycle pulse when a fin-terminated run reaches OFF
//   active_cnt   number of channels not in OFF
//   run_cycles   (only with NODE_GATE_RUN_CYCLES_EN) 32-bit RUN+DRAIN cycle
//                counter per channel, saturating, cleared on each grant
//
// Optional feature macro: NODE_GATE_RUN_CYCLES_EN
// -----------------------------------------------------------------------------
module node_gate_ctrl #(
   parameter int CHANNELS   = 4,
   parameter int MAX_ACTIVE = 2,
   parameter int RES_HOLD   = 4
) (
   input  logic                            clk,
   input  logic                            res_n,
   input  logic [CHANNELS-1:0]             activate,
   input  logic [CHANNELS-1:0]             fin,
   input  logic [CHANNELS-1:0]             bus_busy,
   output logic [CHANNELS-1:0]             clk_en,
   output logic [CHANNELS-1:0]             res_n_gated,
   output logic [CHANNELS-1:0]             sel,
   output logic [CHANNELS-1:0]             done,
   output logic [$clog2(CHANNELS+1)-1:0]   active_cnt
`ifdef NODE_GATE_RUN_CYCLES_EN
   ,
   output logic [CHANNELS*32-1:0]          run_cycles
`endif
);

   localparam int               CNT_W     = $clog2(CHANNELS + 1);
   localparam int               PTR_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam logic [7:0]       HOLD_LAST = 8'(RES_HOLD - 1);
   localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_ACTIVE);

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_HOLD  = 2'd1,
      ST_RUN   = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   state_t              state_q [CHANNELS];
   state_t              state_d [CHANNELS];
   logic [7:0]          hold_q  [CHANNELS];
   logic [7:0]          hold_d  [CHANNELS];
   logic [CHANNELS-1:0] fin_q, fin_d;
   logic [CHANNELS-1:0] done_d;
   logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic                grant_vld;
   logic [PTR_W-1:0]    grant_idx;
   logic [CHANNELS-1:0] clk_en_d, res_n_gated_d, sel_d;
   logic [CNT_W-1:0]    active_d;

   // ---------------------------------------------------------------------------
   // Next-state logic: round-robin admission plus the per-channel FSMs.
   // ---------------------------------------------------------------------------
   always_comb begin
      int idx;
      // NOTE: every combinational output gets a default before any branch so
      // no path leaves it unassigned, which would otherwise infer a latch.
      grant_vld = 1'b0;
      grant_idx = '0;
      rr_ptr_d  = rr_ptr_q;
      fin_d     = fin_q;
      done_d    = '0;
      idx       = 0;

      // active_cnt is the registered count of the current states, so a slot
      // freed by a channel reaching OFF becomes grantable in that OFF cycle.
      if (active_cnt < MAX_CNT) begin
         for (int k = 0; k < CHANNELS; k++) begin
            idx = (int'(rr_ptr_q) + k) % CHANNELS;
            if (!grant_vld && state_q[idx] == ST_OFF && activate[idx]) begin
               grant_vld = 1'b1;
               grant_idx = PTR_W'(idx);
            end
         end
      end

      if (grant_vld) begin
         rr_ptr_d = (int'(grant_idx) == CHANNELS - 1) ? '0 : grant_idx + PTR_W'(1);
      end

      for (int i = 0; i < CHANNELS; i++) begin
         state_d[i] = state_q[i];
         hold_d[i]  = hold_q[i];
         unique case (state_q[i])
            ST_OFF: begin
               if (grant_vld && int'(grant_idx) == i) begin
                  state_d[i] = ST_HOLD;
                  hold_d[i]  = '0;
               end
            end
            ST_HOLD: begin
               // Dropping the request aborts the power-up before RUN.
               if (!activate[i]) begin
                  state_d[i] = ST_OFF;
               end else if (hold_q[i] == HOLD_LAST) begin
                  state_d[i] = ST_RUN;
               end else begin
                  hold_d[i] = hold_q[i] + 8'd1;
               end
            end
            ST_RUN: begin
               if (fin[i]) begin
                  fin_d[i] = 1'b1;
               end
               if (fin[i] || !activate[i]) begin
                  state_d[i] = ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (!bus_busy[i]) begin
                  state_d[i] = ST_OFF;
                  done_d[i]  = fin_q[i];
                  fin_d[i]   = 1'b0;
               end
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Output decode of the next state; registered below so every output pin
   // comes straight from a flop.
   // ---------------------------------------------------------------------------
   always_comb begin
      clk_en_d      = '0;
      res_n_gated_d = '0;
      sel_d         = '0;
      active_d      = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         unique case (state_d[i])
            ST_OFF:  ;
            ST_HOLD: clk_en_d[i] = 1'b1;
            ST_RUN, ST_DRAIN: begin
               clk_en_d[i]      = 1'b1;
               res_n_gated_d[i] = 1'b1;
               sel_d[i]         = 1'b1;
            end
         endcase
         if (state_d[i] != ST_OFF) begin
            active_d = active_d + CNT_W'(1);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // State and output registers.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         // NOTE: these per-channel arrays are control state, not storage, so
         // they are reset along with everything else.
         for (int i = 0; i < CHANNELS; i++) begin
            state_q[i] <= ST_OFF;
            hold_q[i]  <= '0;
         end
         fin_q       <= '0;
         rr_ptr_q    <= '0;
         clk_en      <= '0;
         res_n_gated <= '0;
         sel         <= '0;
         done        <= '0;
         active_cnt  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // from before this edge, independent of statement order.
         for (int i = 0; i < CHANNELS; i++) begin
            state_q[i] <= state_d[i];
            hold_q[i]  <= hold_d[i];
         end
         fin_q       <= fin_d;
         rr_ptr_q    <= rr_ptr_d;
         clk_en      <= clk_en_d;
         res_n_gated <= res_n_gated_d;
         sel         <= sel_d;
         done        <= done_d;
         active_cnt  <= active_d;
      end
   end

`ifdef NODE_GATE_RUN_CYCLES_EN
   // Per-channel occupancy counters: count RUN and DRAIN cycles, restart on
   // each grant, keep the last run's value while the channel sits in OFF.
   logic [31:0] run_q [CHANNELS];

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         for (int i = 0; i < CHANNELS; i++) begin
            run_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (state_q[i] == ST_OFF && state_d[i] == ST_HOLD) begin
               run_q[i] <= '0;
            end else if ((state_q[i] == ST_RUN || state_q[i] == ST_DRAIN) &&
                         run_q[i] != 32'hFFFF_FFFF) begin
               run_q[i] <= run_q[i] + 32'd1;
            end
         end
      end
   end

   always_comb begin
      run_cycles = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         run_cycles[i*32 +: 32] = run_q[i];
      end
   end
`endif

endmodule

// File: tb/tb_node_gate_ctrl.sv
// -----------------------------------------------------------------------------
// tb_node_gate_ctrl
//   Three instances share one stimulus: MAX_ACTIVE = 2, 1 and 4 (CHANNELS = 4,
//   RES_HOLD = 4). A behavioural model tracks, per channel, the number of
//   cycles since its grant (negative when off) plus drain / fin flags, and
//   predicts every output after every edge. Directed scenarios are followed
//   by a randomized run.
// -----------------------------------------------------------------------------
module tb_node_gate_ctrl;

   localparam int CH = 4;
   localparam int RH = 4;
   localparam int CW = $clog2(CH + 1);
   localparam int NI = 3;

   logic          clk = 1'b0;
   logic          res_n = 1'b0;
   logic [CH-1:0] activate = '0;
   logic [CH-1:0] fin = '0;
   logic [CH-1:0] bus_busy = '0;

   logic [CH-1:0] clk_en_o [NI];
   logic [CH-1:0] rng_o    [NI];
   logic [CH-1:0] sel_o    [NI];
   logic [CH-1:0] done_o   [NI];
   logic [CW-1:0] cnt_o    [NI];
`ifdef NODE_GATE_RUN_CYCLES_EN
   logic [CH*32-1:0] rc_o  [NI];
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      node_gate_ctrl #(
         .CHANNELS   (CH),
         .MAX_ACTIVE ((g == 0) ? 2 : ((g == 1) ? 1 : 4)),
         .RES_HOLD   (RH)
      ) dut (
         .clk         (clk),
         .res_n       (res_n),
         .activate    (activate),
         .fin         (fin),
         .bus_busy    (bus_busy),
         .clk_en      (clk_en_o[g]),
         .res_n_gated (rng_o[g]),
         .sel         (sel_o[g]),
         .done        (done_o[g]),
         .active_cnt  (cnt_o[g])
`ifdef NODE_GATE_RUN_CYCLES_EN
         ,
         .run_cycles  (rc_o[g])
`endif
      );
   end

   // ---------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------
   int     age [NI][CH];   // cycles since grant, -1 when off
   bit     drn [NI][CH];   // released, waiting for the bus to go idle
   bit     fsn [NI][CH];   // fin seen during this run
   bit     dn  [NI][CH];   // expected done output
   longint cyc [NI][CH];   // expected run_cycles
   int     ptr [NI];

   function automatic int max_of(input int m);
      return (m == 0) ? 2 : ((m == 1) ? 1 : 4);
   endfunction

   task automatic model_reset();
      for (int m = 0; m < NI; m++) begin
         ptr[m] = 0;
         for (int c = 0; c < CH; c++) begin
            age[m][c] = -1;
            drn[m][c] = 1'b0;
            fsn[m][c] = 1'b0;
            dn[m][c]  = 1'b0;
            cyc[m][c] = 0;
         end
      end
   endtask

   task automatic model_step();
      int busy;
      int gi;
      int c;
      for (int m = 0; m < NI; m++) begin
         busy = 0;
         gi   = -1;
         for (int k = 0; k < CH; k++) if (age[m][k] >= 0) busy++;
         if (busy < max_of(m)) begin
            for (int k = 0; k < CH; k++) begin
               c = (ptr[m] + k) % CH;
               if (gi < 0 && age[m][c] < 0 && activate[c]) gi = c;
            end
         end
         for (int k = 0; k < CH; k++) begin
            dn[m][k] = 1'b0;
            if (age[m][k] >= RH && cyc[m][k] < 64'hFFFF_FFFF) cyc[m][k]++;
            if (age[m][k] < 0) begin
               if (k == gi) begin
                  age[m][k] = 0;
                  cyc[m][k] = 0;
               end
            end else if (age[m][k] < RH) begin
               if (!activate[k]) age[m][k] = -1;
               else age[m][k]++;
            end else if (!drn[m][k]) begin
               if (fin[k]) fsn[m][k] = 1'b1;
               if (fin[k] || !activate[k]) drn[m][k] = 1'b1;
               age[m][k]++;
            end else if (!bus_busy[k]) begin
               age[m][k] = -1;
               drn[m][k] = 1'b0;
               dn[m][k]  = fsn[m][k];
               fsn[m][k] = 1'b0;
            end else begin
               age[m][k]++;
            end
         end
         if (gi >= 0) ptr[m] = (gi + 1) % CH;
      end
   endtask

   // ---------------------------------------------------------------------------
   // Checking helpers
   // ---------------------------------------------------------------------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic compare_all();
      logic [CH-1:0] e_ce, e_rg, e_dn;
      int            e_cnt;
      for (int m = 0; m < NI; m++) begin
         e_ce  = '0;
         e_rg  = '0;
         e_dn  = '0;
         e_cnt = 0;
         for (int c = 0; c < CH; c++) begin
            e_ce[c] = (age[m][c] >= 0);
            e_rg[c] = (age[m][c] >= RH);
            e_dn[c] = dn[m][c];
            if (age[m][c] >= 0) e_cnt++;
         end
         check($sformatf("i%0d.clk_en", m),      32'(clk_en_o[m]), 32'(e_ce));
         check($sformatf("i%0d.res_n_gated", m), 32'(rng_o[m]),    32'(e_rg));
         check($sformatf("i%0d.sel", m),         32'(sel_o[m]),    32'(e_rg));
         check($sformatf("i%0d.done", m),        32'(done_o[m]),   32'(e_dn));
         check($sformatf("i%0d.active_cnt", m),  32'(cnt_o[m]),    32'(e_cnt));
`ifdef NODE_GATE_RUN_CYCLES_EN
         for (int c = 0; c < CH; c++) begin
            check($sformatf("i%0d.run_cycles[%0d]", m, c), rc_o[m][c*32 +: 32], 32'(cyc[m][c]));
         end
`endif
      end
   endtask

   // One clock cycle: the model consumes the inputs that the DUT samples on
   // this edge, then outputs are compared 1 time unit after the edge.
   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Leaves the bench 1 unit after an edge with reset just released:
   // the next edge is cycle 0's sampling edge.
   task automatic do_reset();
      #2;
      res_n    = 1'b0;
      activate = '0;
      fin      = '0;
      bus_busy = '0;
      model_reset();
      @(posedge clk);
      #1;
      compare_all();
      res_n = 1'b1;
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      int            order [5];
      int            exp_order [5];
      int            nrec;
      logic [CH-1:0] prev;

      exp_order = '{0, 1, 2, 3, 0};
      model_reset();

      // Single run on channel 0.
      do_reset();
      activate = 4'b0001;
      step();
      check("single.clk_en_c1", 32'(clk_en_o[0][0]), 32'd1);
      steps(3);
      check("single.rng_c4", 32'(rng_o[0][0]), 32'd0);
      step();
      check("single.rng_c5", 32'(rng_o[0][0]), 32'd1);
      check("single.sel_c5", 32'(sel_o[0][0]), 32'd1);
      steps(15);
      fin = 4'b0001;
      step();
      fin      = '0;
      activate = '0;
      check("single.sel_drain_c21", 32'(sel_o[0][0]), 32'd1);
      check("single.done_c21", 32'(done_o[0][0]), 32'd0);
      step();
      check("single.done_c22", 32'(done_o[0][0]), 32'd1);
      check("single.clk_en_c22", 32'(clk_en_o[0][0]), 32'd0);
      step();
      check("single.done_c23", 32'(done_o[0][0]), 32'd0);

      // Admission cap with MAX_ACTIVE = 2 (instance 0).
      do_reset();
      activate = 4'b1111;
      step();
      check("cap.clk_en_c1", 32'(clk_en_o[0]), 32'b0001);
      step();
      check("cap.clk_en_c2", 32'(clk_en_o[0]), 32'b0011);
      steps(8);
      check("cap.cnt_c10", 32'(cnt_o[0]), 32'd2);
      check("cap.clk_en_c10", 32'(clk_en_o[0]), 32'b0011);
      fin      = 4'b0001;
      activate = 4'b1110;
      step();
      fin = '0;
      steps(2);
      check("cap.next_grant_ch2", 32'(clk_en_o[0]), 32'b0110);
      check("cap.cnt_c13", 32'(cnt_o[0]), 32'd2);

      // Round-robin fairness with MAX_ACTIVE = 1 (instance 1).
      do_reset();
      activate = 4'b1111;
      fin      = 4'b1111;
      prev     = clk_en_o[1];
      nrec     = 0;
      for (int i = 0; i < 5; i++) order[i] = -1;
      for (int s = 0; s < 100 && nrec < 5; s++) begin
         step();
         for (int c = 0; c < CH; c++) begin
            if (clk_en_o[1][c] && !prev[c] && nrec < 5) begin
               order[nrec] = c;
               nrec++;
            end
         end
         prev = clk_en_o[1];
      end
      check("rr.grants_seen", 32'(nrec), 32'd5);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("rr.order[%0d]", i), 32'(order[i]), 32'(exp_order[i]));
      end

      // Drain stall on channel 1.
      do_reset();
      activate = 4'b0010;
      bus_busy = 4'b0010;
      steps(8);
      fin = 4'b0010;
      step();
      fin = '0;
      check("drain.sel_c9", 32'(sel_o[0][1]), 32'd1);
      for (int i = 0; i < 7; i++) begin
         step();
         check("drain.sel_stall", 32'(sel_o[0][1]), 32'd1);
         check("drain.done_stall", 32'(done_o[0][1]), 32'd0);
      end
      bus_busy = '0;
      activate = '0;
      step();
      check("drain.done", 32'(done_o[0][1]), 32'd1);
      check("drain.clk_en_off", 32'(clk_en_o[0][1]), 32'd0);
      check("drain.sel_off", 32'(sel_o[0][1]), 32'd0);

      // Abort in HOLD on channel 2.
      do_reset();
      activate = 4'b0100;
      steps(2);
      activate = '0;
      step();
      for (int m = 0; m < NI; m++) begin
         check($sformatf("abort.i%0d.clk_en", m), 32'(clk_en_o[m][2]), 32'd0);
      end
      steps(6);

      // Asynchronous reset in the middle of RUN on three channels.
      do_reset();
      activate = 4'b0111;
      steps(12);
      check("arst.rng_before", 32'(rng_o[2]), 32'b0111);
      #2;
      res_n = 1'b0;
      #1;
      for (int m = 0; m < NI; m++) begin
         check($sformatf("arst.i%0d.clk_en", m), 32'(clk_en_o[m]), 32'd0);
         check($sformatf("arst.i%0d.rng", m),    32'(rng_o[m]),    32'd0);
         check($sformatf("arst.i%0d.sel", m),    32'(sel_o[m]),    32'd0);
         check($sformatf("arst.i%0d.done", m),   32'(done_o[m]),   32'd0);
         check($sformatf("arst.i%0d.cnt", m),    32'(cnt_o[m]),    32'd0);
`ifdef NODE_GATE_RUN_CYCLES_EN
         for (int c = 0; c < CH; c++) begin
            check($sformatf("arst.i%0d.run_cycles[%0d]", m, c), rc_o[m][c*32 +: 32], 32'd0);
         end
`endif
      end
      model_reset();

      // Randomized traffic.
      do_reset();
      for (int s = 0; s < 600; s++) begin
         for (int c = 0; c < CH; c++) begin
            if ($urandom_range(7) == 0) activate[c] = ~activate[c];
            fin[c]      = ($urandom_range(5) == 0);
            bus_busy[c] = ($urandom_range(2) == 0);
         end
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
